// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style floating-point adder/subtractor with valid/ready flow control.
// Stage 1 unpacks and aligns, stage 2 adds and normalises, stage 3 rounds to nearest even and packs.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int SW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXPW_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXPW_ZERO = {(EXP_W+1){1'b0}};
    localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [31:0] lzc(input logic [SW-1:0] v);
        lzc = 32'(SW);
        for (int i = 0; i < SW; i++) begin
            lzc = v[i] ? 32'(SW - 1 - i) : lzc;
        end
    endfunction

    logic advance_s;
    logic a_sign_s, b_sign_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s, x_sign_s, y_sign_s;
    logic [EXP_W-1:0] a_exp_s, b_exp_s, x_exp_s, y_exp_s, diff_s;
    logic [MAN_W:0]   a_sig_s, b_sig_s, x_sig_s, y_sig_s;
    logic [2*SW-1:0]  y_wide_s;
    logic [SW-1:0]    y_al_s;
    logic             spec_s;
    logic [W-1:0]     spec_res_s;
    logic [3:0]       spec_flg_s;

    logic             v1_r, s1_xs_r, s1_ys_r, s1_spec_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [SW-1:0]    s1_xm_r, s1_ym_r;
    logic [W-1:0]     s1_sres_r;
    logic [3:0]       s1_sflg_r;

    logic [SW:0]      sum_s;
    logic [31:0]      lz_s, lim_s, sh_s;
    logic [SW-1:0]    norm_s, mant_s;
    logic [EXP_W:0]   nexp_s;
    logic             nsign_s;

    logic             v2_r, s2_sign_r, s2_spec_r;
    logic [EXP_W:0]   s2_exp_r;
    logic [SW-1:0]    s2_mant_r;
    logic [W-1:0]     s2_sres_r;
    logic [3:0]       s2_sflg_r;

    logic             up_s, inexact_s;
    logic [MAN_W+1:0] rnd_s;
    logic [EXP_W:0]   fexp_s;
    logic [MAN_W-1:0] ffrac_s;
    logic [W-1:0]     res_s;
    logic [3:0]       flg_s;

    logic             v3_r;
    logic [W-1:0]     result_r;
    logic [3:0]       flags_r;

    assign advance_s = !v3_r || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = v3_r;
    assign result    = result_r;
    assign flags     = flags_r;

    // Stage 1: unpack, classify specials, order by magnitude and align the smaller operand.
    always_comb begin
        a_sign_s = a[W-1];
        b_sign_s = b[W-1] ^ op;
        a_nan_s  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] != FRAC_ZERO);
        b_nan_s  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] != FRAC_ZERO);
        a_inf_s  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] == FRAC_ZERO);
        b_inf_s  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] == FRAC_ZERO);
        a_exp_s  = (a[W-2:MAN_W] == EXP_ZERO) ? EXP_ONE : a[W-2:MAN_W];
        b_exp_s  = (b[W-2:MAN_W] == EXP_ZERO) ? EXP_ONE : b[W-2:MAN_W];
        a_sig_s  = {a[W-2:MAN_W] != EXP_ZERO, a[MAN_W-1:0]};
        b_sig_s  = {b[W-2:MAN_W] != EXP_ZERO, b[MAN_W-1:0]};
        swap_s   = b[W-2:0] > a[W-2:0];
        x_sign_s = swap_s ? b_sign_s : a_sign_s;
        y_sign_s = swap_s ? a_sign_s : b_sign_s;
        x_exp_s  = swap_s ? b_exp_s : a_exp_s;
        y_exp_s  = swap_s ? a_exp_s : b_exp_s;
        x_sig_s  = swap_s ? b_sig_s : a_sig_s;
        y_sig_s  = swap_s ? a_sig_s : b_sig_s;
        diff_s   = x_exp_s - y_exp_s;
        y_wide_s = {y_sig_s, 3'b000, {SW{1'b0}}} >> diff_s;
        if (32'(diff_s) >= 32'(MAN_W + 3)) begin
            y_al_s = {{(SW-1){1'b0}}, |y_sig_s};
        end else begin
            y_al_s = y_wide_s[2*SW-1:SW] | {{(SW-1){1'b0}}, |y_wide_s[SW-1:0]};
        end
        spec_s     = 1'b1;
        spec_res_s = QNAN;
        spec_flg_s = 4'b0000;
        if (a_nan_s || b_nan_s) begin
            spec_flg_s = {(a_nan_s && !a[MAN_W-1]) || (b_nan_s && !b[MAN_W-1]), 3'b000};
        end else if (a_inf_s && b_inf_s && (a_sign_s != b_sign_s)) begin
            spec_flg_s = 4'b1000;
        end else if (a_inf_s) begin
            spec_res_s = {a_sign_s, EXP_ONES, FRAC_ZERO};
        end else if (b_inf_s) begin
            spec_res_s = {b_sign_s, EXP_ONES, FRAC_ZERO};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Stage 2: magnitude add/subtract, then normalise (right by one on carry, else left by lzc).
    always_comb begin
        if (s1_xs_r != s1_ys_r) begin
            sum_s = {1'b0, s1_xm_r} - {1'b0, s1_ym_r};
        end else begin
            sum_s = {1'b0, s1_xm_r} + {1'b0, s1_ym_r};
        end
        lz_s   = lzc(sum_s[SW-1:0]);
        lim_s  = 32'(s1_exp_r) - 32'd1;
        sh_s   = (lz_s < lim_s) ? lz_s : lim_s;
        norm_s = sum_s[SW-1:0] << sh_s;
        if (sum_s[SW]) begin
            mant_s = {sum_s[SW:2], sum_s[1] | sum_s[0]};
            nexp_s = {1'b0, s1_exp_r} + EXPW_ONE;
        end else begin
            mant_s = norm_s;
            nexp_s = norm_s[SW-1] ? (EXP_W+1)'(32'(s1_exp_r) - sh_s) : EXPW_ZERO;
        end
        // An exact cancellation is +0; like-signed zeros keep their sign.
        nsign_s = ((sum_s == {(SW+1){1'b0}}) && (s1_xs_r != s1_ys_r)) ? 1'b0 : s1_xs_r;
    end

    // Stage 3: round to nearest even, detect overflow, pack result and flags.
    always_comb begin
        up_s      = s2_mant_r[2] & (s2_mant_r[1] | s2_mant_r[0] | s2_mant_r[3]);
        inexact_s = s2_mant_r[2] | s2_mant_r[1] | s2_mant_r[0];
        rnd_s     = {1'b0, s2_mant_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, up_s};
        if (rnd_s[MAN_W+1]) begin
            fexp_s  = s2_exp_r + EXPW_ONE;
            ffrac_s = FRAC_ZERO;
        end else if ((s2_exp_r == EXPW_ZERO) && rnd_s[MAN_W]) begin
            fexp_s  = EXPW_ONE;
            ffrac_s = rnd_s[MAN_W-1:0];
        end else begin
            fexp_s  = s2_exp_r;
            ffrac_s = rnd_s[MAN_W-1:0];
        end
        if (s2_spec_r) begin
            res_s = s2_sres_r;
            flg_s = s2_sflg_r;
        end else if (fexp_s >= {1'b0, EXP_ONES}) begin
            res_s = {s2_sign_r, EXP_ONES, FRAC_ZERO};
            flg_s = 4'b0101;
        end else begin
            res_s = {s2_sign_r, fexp_s[EXP_W-1:0], ffrac_s};
            flg_s = {2'b00, (fexp_s == EXPW_ZERO) && inexact_s, inexact_s};
        end
    end

    // Pipeline registers: all stages shift together on advance and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0; s1_xs_r <= 1'b0; s1_ys_r <= 1'b0; s1_spec_r <= 1'b0;
            s1_exp_r <= EXP_ZERO; s1_xm_r <= {SW{1'b0}}; s1_ym_r <= {SW{1'b0}};
            s1_sres_r <= {W{1'b0}}; s1_sflg_r <= 4'b0000;
            v2_r <= 1'b0; s2_sign_r <= 1'b0; s2_spec_r <= 1'b0; s2_exp_r <= EXPW_ZERO;
            s2_mant_r <= {SW{1'b0}}; s2_sres_r <= {W{1'b0}}; s2_sflg_r <= 4'b0000;
            v3_r <= 1'b0; result_r <= {W{1'b0}}; flags_r <= 4'b0000;
        end else if (advance_s) begin
            v1_r <= in_valid; s1_xs_r <= x_sign_s; s1_ys_r <= y_sign_s; s1_spec_r <= spec_s;
            s1_exp_r <= x_exp_s; s1_xm_r <= {x_sig_s, 3'b000}; s1_ym_r <= y_al_s;
            s1_sres_r <= spec_res_s; s1_sflg_r <= spec_flg_s;
            v2_r <= v1_r; s2_sign_r <= nsign_s; s2_spec_r <= s1_spec_r; s2_exp_r <= nexp_s;
            s2_mant_r <= mant_s; s2_sres_r <= s1_sres_r; s2_sflg_r <= s1_sflg_r;
            v3_r <= v2_r; result_r <= res_s; flags_r <= flg_s;
        end else begin
            v1_r <= v1_r;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed cases, randomized stream against an exact integer model,
// backpressure, reset while busy, and a binary32 instance.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [15:0] a = 16'h0000, b = 16'h0000, result;
    logic [3:0]  flags;
    logic        s_in_valid = 1'b0, s_op = 1'b0, s_out_ready = 1'b1;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_a = 32'h0, s_b = 32'h0, s_result;
    logic [3:0]  s_flags;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .flags(s_flags)
    );

    // Exact half-precision model: operands as integers in units of 2^-24, exact sum, then RNE.
    function automatic logic [19:0] ref_add16(input logic [15:0] x, input logic [15:0] y,
                                              input logic sub);
        logic   sx, sy, x_nan, y_nan, x_inf, y_inf, sgn, up;
        longint vx, vy, sum, mag, keep, rem, half_ulp;
        int     p, sh;
        sx    = x[15];
        sy    = y[15] ^ sub;
        x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
        y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'h000);
        x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
        y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'h000);
        if (x_nan || y_nan)
            return {(x_nan && !x[9]) || (y_nan && !y[9]), 3'b000, 16'h7E00};
        if (x_inf && y_inf)
            return (sx != sy) ? {4'b1000, 16'h7E00} : {4'b0000, sx, 15'h7C00};
        if (x_inf) return {4'b0000, sx, 15'h7C00};
        if (y_inf) return {4'b0000, sy, 15'h7C00};
        vx = (x[14:10] == 5'h00) ? longint'(x[9:0]) : (longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1));
        vy = (y[14:10] == 5'h00) ? longint'(y[9:0]) : (longint'({1'b1, y[9:0]}) << (int'(y[14:10]) - 1));
        if (sx) vx = -vx;
        if (sy) vy = -vy;
        sum = vx + vy;
        if (sum == 0) return {4'b0000, sx && sy, 15'h0000};
        sgn = (sum < 0);
        mag = sgn ? -sum : sum;
        if (mag < 2048) return {4'b0000, sgn, mag[14:0]};
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        sh       = p - 10;
        keep     = mag >> sh;
        rem      = mag - (keep << sh);
        half_ulp = longint'(1) << (sh - 1);
        up       = (rem > half_ulp) || ((rem == half_ulp) && keep[0]);
        keep     = keep + (up ? 1 : 0);
        if (keep == 2048) begin
            keep = 1024;
            sh++;
        end
        if (sh + 1 >= 31) return {4'b0101, sgn, 15'h7C00};
        return {3'b000, rem != 0, sgn, 5'(sh + 1), keep[9:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] ta[15], tb_[15], tr[15];
        logic        to[15];
        logic [3:0]  tf[15];
        int          lat;
        ta  = '{16'h4900, 16'h4900, 16'h7BFF, 16'h7C00, 16'h7C00, 16'h3C00, 16'h3C01, 16'h0200,
                16'h3C00, 16'h8000, 16'h7D00, 16'h0000, 16'hFC00, 16'h3C00, 16'h3C00};
        tb_ = '{16'h4500, 16'h4500, 16'h7BFF, 16'h7C00, 16'h3C00, 16'h1000, 16'h1000, 16'h0200,
                16'h3C00, 16'h8000, 16'h3C00, 16'h8000, 16'h3C00, 16'h7C00, 16'h3BFF};
        to  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tr  = '{16'h4B80, 16'h4500, 16'h7C00, 16'h7E00, 16'h7C00, 16'h3C00, 16'h3C02, 16'h0400,
                16'h0000, 16'h8000, 16'h7E00, 16'h0000, 16'hFC00, 16'hFC00, 16'h1000};
        tf  = '{4'h0, 4'h0, 4'h5, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a = ta[i]; b = tb_[i]; op = to[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
            checks++; if (result !== tr[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, result, tr[i]); end
            checks++; if (flags !== tf[i]) begin errors++; $display("FAIL dir%0d_flags: got %b expected %b", i, flags, tf[i]); end
        end
    endtask

    task automatic test_random();
        int          sent, got;
        logic [19:0] e;
        sent = 0; got = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 300) && ($urandom_range(0, 4) != 0);
            a  = 16'($urandom());
            b  = ($urandom_range(0, 1) != 0) ? 16'($urandom()) : {a[15:10], 10'($urandom())};
            op = 1'($urandom());
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: got %h with nothing outstanding", {flags, result});
                end else begin
                    e = exp_q.pop_front();
                    if ({flags, result} !== e) begin errors++; $display("FAIL rnd_result: got %h expected %h", {flags, result}, e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add16(a, b, op));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 300) begin errors++; $display("FAIL rnd_count: got %0d expected 300", got); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa[6], ob[6];
        logic        oop[6];
        int          issued, got, full_at;
        logic [19:0] e;
        for (int i = 0; i < 6; i++) begin
            oa[i] = 16'($urandom()); ob[i] = 16'($urandom()); oop[i] = 1'($urandom());
        end
        issued = 0; got = 0; full_at = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (issued < 6);
            if (issued < 6) begin
                a = oa[issued]; b = ob[issued]; op = oop[issued];
            end
            #1;
            if (in_valid && !in_ready && full_at < 0) begin
                full_at = issued;
                checks++; if (issued != 3) begin errors++; $display("FAIL bb_full: in_ready fell after %0d accepts, expected 3", issued); end
            end
            if (cyc >= 5 && in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bb_resume: in_ready %b expected 1 at cycle %0d", in_ready, cyc); end
            end
            if (out_valid && !out_ready) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 20'h00000;
                checks++; if (exp_q.size() == 0 || {flags, result} !== e) begin errors++; $display("FAIL bb_hold: got %h expected %h", {flags, result}, e); end
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h00000;
                checks++; if ({flags, result} !== e) begin errors++; $display("FAIL bb_order: got %h expected %h", {flags, result}, e); end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add16(a, b, op));
                issued++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6 || full_at != 3) begin errors++; $display("FAIL bb_count: got %0d results full_at %0d, expected 6 and 3", got, full_at); end
    endtask

    task automatic test_reset_midflight();
        int lat, extra;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h3C00; b = 16'h4000; op = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mid_result: got %h expected 0000", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL mid_flags: got %b expected 0000", flags); end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h4900; b = 16'h4500; op = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL mid_latency: got %0d expected 3", lat); end
        checks++; if (result !== 16'h4B80) begin errors++; $display("FAIL mid_post_result: got %h expected 4B80", result); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL mid_stale: got %0d extra results expected 0", extra); end
    endtask

    task automatic test_fp32();
        int lat;
        @(negedge clk);
        s_a = 32'h41200000; s_b = 32'h40A00000; s_op = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL f32_latency: got %0d expected 3", lat); end
        checks++; if (s_result !== 32'h41700000) begin errors++; $display("FAIL f32_result: got %h expected 41700000", s_result); end
        checks++; if (s_flags !== 4'b0000) begin errors++; $display("FAIL f32_flags: got %b expected 0000", s_flags); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        test_fp32();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
